quad_decoder: RTL

- Parametrised quadrature encoder decoder that succeeds the single-channel up/down counter.
- Adds a glitch filter, a run-time selectable x4/x2/x1 resolution, wrap or saturate counting, and illegal-transition detection.
- Adds a synchronous snapshot port that returns the position and the delta since the previous snapshot.
- Sits between the raw encoder pins and the stroke/LED timing logic of the light painter.

---
 rtl/quad_decoder_if.sv | 31 +++
 rtl/quad_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/quad_decoder_if.sv
// rtl/quad_decoder_if.sv - encoder pin, control and position/snapshot bundle for quad_decoder
//
// master: drives a_in, b_in, res_mode, snap, clear_err; reads the rest.
// slave : the decoder; reads the pins and controls, drives count, dir, step,
//         snap_count, snap_delta, snap_valid and err.
interface quad_decoder_if #(
    parameter int COUNT_W = 10
);
    logic               a_in;
    logic               b_in;
    logic [1:0]         res_mode;
    logic               snap;
    logic               clear_err;
    logic [COUNT_W-1:0] count;
    logic               dir;
    logic               step;
    logic [COUNT_W-1:0] snap_count;
    logic [COUNT_W-1:0] snap_delta;
    logic               snap_valid;
    logic               err;

    modport master (
        output a_in, b_in, res_mode, snap, clear_err,
        input  count, dir, step, snap_count, snap_delta, snap_valid, err
    );

    modport slave (
        input  a_in, b_in, res_mode, snap, clear_err,
        output count, dir, step, snap_count, snap_delta, snap_valid, err
    );
endinterface

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - filtered quadrature decoder with resolution select and snapshots
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-low reset
//   bus    - quad_decoder_if.slave:
//              a_in, b_in   asynchronous encoder channels
//              res_mode     0 = x4, 1 = x2, 2 = x1, 3 = x4
//              snap         one-cycle snapshot request
//              clear_err    clears the sticky error flag
//              count        current position
//              dir          last valid direction (1 = forward)
//              step         one-cycle pulse per counted edge
//              snap_count   position captured by the last snapshot
//              snap_delta   position change since the previous snapshot
//              snap_valid   one-cycle pulse when snap_* update
//              err          sticky illegal-transition flag
module quad_decoder #(
    parameter int COUNT_W    = 10,
    parameter int FILTER_LEN = 4,
    parameter int WRAP       = 1
) (
    input  logic           clk,
    input  logic           reset,
    quad_decoder_if.slave  bus
);
    localparam int FILT_W = 8;
    localparam int ARM_W  = 9;
    localparam logic [FILT_W-1:0]  FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [ARM_W-1:0]   ARM_LOAD  = ARM_W'(FILTER_LEN + 3);
    localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);

    logic               a_s1, a_s2, b_s1, b_s2;
    logic [FILT_W-1:0]  a_fcnt, b_fcnt;
    logic               a_filt, b_filt;
    logic [ARM_W-1:0]   arm_cnt;
    logic [1:0]         prev;
    logic [COUNT_W-1:0] count_q, snap_count_q, snap_delta_q, base_q;
    logic               dir_q, step_q, snap_valid_q, err_q;

    logic [1:0]         cur, chg, fwd_next;
    logic               armed, valid, illegal, fwd, counted;
    logic [COUNT_W-1:0] next_count;

    assign cur     = {a_filt, b_filt};
    assign chg     = prev ^ cur;
    assign armed   = (arm_cnt == '0);
    assign valid   = armed && (chg == 2'b01 || chg == 2'b10);
    assign illegal = armed && (chg == 2'b11);
    assign fwd     = (cur == fwd_next);

    // Forward rotation 00 -> 10 -> 11 -> 01 -> 00.
    always_comb begin
        fwd_next = 2'b00;
        case (prev)
            2'b00:   fwd_next = 2'b10;
            2'b10:   fwd_next = 2'b11;
            2'b11:   fwd_next = 2'b01;
            default: fwd_next = 2'b00;
        endcase
    end

    always_comb begin
        counted = 1'b0;
        case (bus.res_mode)
            2'd1:    counted = valid && chg[1];
            2'd2:    counted = valid && ((prev == 2'b00 && cur == 2'b10) ||
                                         (prev == 2'b10 && cur == 2'b00));
            default: counted = valid;
        endcase
    end

    // next_count is also what a coincident snapshot captures.
    always_comb begin
        next_count = count_q;
        if (counted) begin
            if (fwd) begin
                if (WRAP != 0 || count_q != CNT_MAX)
                    next_count = count_q + CNT_ONE;
            end else begin
                if (WRAP != 0 || count_q != '0)
                    next_count = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_s1         <= 1'b0;
            a_s2         <= 1'b0;
            b_s1         <= 1'b0;
            b_s2         <= 1'b0;
            a_fcnt       <= '0;
            b_fcnt       <= '0;
            a_filt       <= 1'b0;
            b_filt       <= 1'b0;
            arm_cnt      <= ARM_LOAD;
            prev         <= 2'b00;
            count_q      <= '0;
            dir_q        <= 1'b0;
            step_q       <= 1'b0;
            err_q        <= 1'b0;
            snap_count_q <= '0;
            snap_delta_q <= '0;
            snap_valid_q <= 1'b0;
            base_q       <= '0;
        end else begin
            a_s1 <= bus.a_in;
            a_s2 <= a_s1;
            b_s1 <= bus.b_in;
            b_s2 <= b_s1;

            // A channel is accepted only after FILTER_LEN consecutive
            // differing cycles; any agreeing cycle restarts the count.
            if (a_s2 != a_filt) begin
                if (a_fcnt == FILT_LAST) begin
                    a_filt <= a_s2;
                    a_fcnt <= '0;
                end else begin
                    a_fcnt <= a_fcnt + FILT_W'(1);
                end
            end else begin
                a_fcnt <= '0;
            end

            if (b_s2 != b_filt) begin
                if (b_fcnt == FILT_LAST) begin
                    b_filt <= b_s2;
                    b_fcnt <= '0;
                end else begin
                    b_fcnt <= b_fcnt + FILT_W'(1);
                end
            end else begin
                b_fcnt <= '0;
            end

            // prev tracks the filtered state even while disarmed so that the
            // first armed comparison starts from the settled pin state.
            prev <= cur;
            if (!armed)
                arm_cnt <= arm_cnt - ARM_W'(1);

            step_q  <= counted;
            count_q <= next_count;
            if (valid)
                dir_q <= fwd;

            if (illegal)
                err_q <= 1'b1;
            else if (bus.clear_err)
                err_q <= 1'b0;

            snap_valid_q <= bus.snap;
            if (bus.snap) begin
                snap_count_q <= next_count;
                snap_delta_q <= next_count - base_q;
                base_q       <= next_count;
            end
        end
    end

    assign bus.count      = count_q;
    assign bus.dir        = dir_q;
    assign bus.step       = step_q;
    assign bus.err        = err_q;
    assign bus.snap_count = snap_count_q;
    assign bus.snap_delta = snap_delta_q;
    assign bus.snap_valid = snap_valid_q;
endmodule
